// File: rtl/shift_unit_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_unit_pipe_if
// Brief    : Operation/result handshake bundle for the pipelined shift unit.
// Revision : 1.0
// ============================================================================
interface shift_unit_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    localparam int c_SHAMT_W = $clog2(WIDTH);

    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_op;
    logic [WIDTH-1:0]     in_data;
    logic [c_SHAMT_W-1:0] in_shamt;
    logic [TAG_W-1:0]     in_tag;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [TAG_W-1:0]     out_tag;
    logic                 out_illegal;

    modport master (
        output in_valid, in_op, in_data, in_shamt, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_data, in_shamt, in_tag, flush, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/shift_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : shift_unit_pipe
// Brief    : Elastic pipelined barrel shifter (SLL/SRL/SRA/ROTR/ROTL) with tag.
// Revision : 1.0
// ============================================================================
module shift_unit_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    shift_unit_pipe_if.slave bus
);
    localparam int         c_LOG_W  = $clog2(WIDTH);
    localparam int         c_BPS    = (c_LOG_W + STAGES - 1) / STAGES;
    localparam logic [2:0] c_OP_SLL  = 3'b000;
    localparam logic [2:0] c_OP_SRL  = 3'b001;
    localparam logic [2:0] c_OP_SRA  = 3'b010;
    localparam logic [2:0] c_OP_ROTR = 3'b011;
    localparam logic [2:0] c_OP_ROTL = 3'b100;

    // Shamt bits handled by stage k; empty for trailing stages that only register.
    function automatic logic [c_LOG_W-1:0] stage_mask(input int k);
        logic [c_LOG_W-1:0] m;
        m = '0;
        for (int b = 0; b < c_LOG_W; b++) begin
            if (b >= k * c_BPS && b < (k + 1) * c_BPS) m[b] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] shift_step(
        input logic [2:0]         op,
        input logic [WIDTH-1:0]   d,
        input logic               sign,
        input logic [c_LOG_W-1:0] shamt,
        input logic [c_LOG_W-1:0] mask
    );
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] fill;
        r = d;
        for (int b = 0; b < c_LOG_W; b++) begin
            fill = {WIDTH{sign}} & ~({WIDTH{1'b1}} >> (1 << b));
            if (mask[b] && shamt[b]) begin
                case (op)
                    c_OP_SLL:  r = r << (1 << b);
                    c_OP_SRL:  r = r >> (1 << b);
                    c_OP_SRA:  r = (r >> (1 << b)) | fill;
                    c_OP_ROTR: r = (r >> (1 << b)) | (r << (WIDTH - (1 << b)));
                    c_OP_ROTL: r = (r << (1 << b)) | (r >> (WIDTH - (1 << b)));
                    default:   r = r;
                endcase
            end
        end
        return r;
    endfunction

    logic [STAGES-1:0]  r_v;
    logic [STAGES-1:0]  r_sign;
    logic [STAGES-1:0]  r_ill;
    logic [2:0]         r_op    [STAGES];
    logic [WIDTH-1:0]   r_data  [STAGES];
    logic [c_LOG_W-1:0] r_shamt [STAGES];
    logic [TAG_W-1:0]   r_tag   [STAGES];

    logic [STAGES-1:0]  w_adv;
    logic [STAGES-1:0]  w_src_v;
    logic [STAGES-1:0]  w_src_sign;
    logic [STAGES-1:0]  w_src_ill;
    logic [2:0]         w_src_op    [STAGES];
    logic [WIDTH-1:0]   w_src_data  [STAGES];
    logic [c_LOG_W-1:0] w_src_shamt [STAGES];
    logic [TAG_W-1:0]   w_src_tag   [STAGES];
    logic [WIDTH-1:0]   w_nxt_data  [STAGES];

    // Advance propagates backwards from the consumer through empty or moving stages.
    always_comb begin : comb_adv
        logic w_down;
        w_down = bus.out_ready;
        w_adv  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_down   = !r_v[k] || w_down;
            w_adv[k] = w_down;
        end
    end

    // Sign is captured from the operand and carried so SRA never re-reads shifted data.
    always_comb begin : comb_src
        w_src_v        = '0;
        w_src_sign     = '0;
        w_src_ill      = '0;
        w_src_v[0]     = bus.in_valid;
        w_src_ill[0]   = (bus.in_op > c_OP_ROTL);
        w_src_sign[0]  = bus.in_data[WIDTH-1];
        w_src_op[0]    = bus.in_op;
        w_src_data[0]  = (bus.in_op > c_OP_ROTL) ? '0 : bus.in_data;
        w_src_shamt[0] = bus.in_shamt;
        w_src_tag[0]   = bus.in_tag;
        for (int k = 1; k < STAGES; k++) begin
            w_src_v[k]     = r_v[k-1];
            w_src_ill[k]   = r_ill[k-1];
            w_src_sign[k]  = r_sign[k-1];
            w_src_op[k]    = r_op[k-1];
            w_src_data[k]  = r_data[k-1];
            w_src_shamt[k] = r_shamt[k-1];
            w_src_tag[k]   = r_tag[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_nxt_data[k] = shift_step(w_src_op[k], w_src_data[k], w_src_sign[k],
                                       w_src_shamt[k], stage_mask(k));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v    <= '0;
            r_sign <= '0;
            r_ill  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_op[k]    <= '0;
                r_data[k]  <= '0;
                r_shamt[k] <= '0;
                r_tag[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (bus.flush) begin
                    r_v[k] <= 1'b0;
                end else if (w_adv[k]) begin
                    r_v[k] <= w_src_v[k];
                    if (w_src_v[k]) begin
                        r_sign[k]  <= w_src_sign[k];
                        r_ill[k]   <= w_src_ill[k];
                        r_op[k]    <= w_src_op[k];
                        r_data[k]  <= w_nxt_data[k];
                        r_shamt[k] <= w_src_shamt[k];
                        r_tag[k]   <= w_src_tag[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready    = w_adv[0];
    assign bus.out_valid   = r_v[STAGES-1];
    assign bus.out_data    = r_data[STAGES-1];
    assign bus.out_tag     = r_tag[STAGES-1];
    assign bus.out_illegal = r_ill[STAGES-1];
endmodule
`default_nettype wire

// File: tb/tb_shift_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_unit_pipe
// Brief    : Scoreboard bench: directed 32x2 vectors plus randomized sweeps.
// Revision : 1.0
// ============================================================================
module tb_shift_unit_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst    = 1'b0;
    logic       rst_sw = 1'b0;
    bit         sw_go  = 1'b0;
    logic [2:0] sw_done = '0;
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] d;
        logic [4:0]  tag;
        logic        ill;
        int          icyc;
        bit          lat;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] d;
        logic [4:0]  sh;
        logic [31:0] ed;
        logic        ill;
    } vec_t;

    vec_t vt [26];
    exp_t mq [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Independent whole-word reference, no per-stage decomposition.
    function automatic logic [63:0] ref_shift(input int w, input logic [2:0] op,
                                              input logic [63:0] d, input int sh);
        logic [63:0] mask;
        logic [63:0] x;
        logic [63:0] r;
        int s;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        s    = sh % w;
        x    = d & mask;
        case (op)
            3'd0: r = (x << s) & mask;
            3'd1: r = x >> s;
            3'd2: begin
                r = x >> s;
                if (x[w-1]) r = r | (mask & ~(mask >> s));
            end
            3'd3: r = ((x >> s) | (x << (w - s))) & mask;
            3'd4: r = ((x << s) | (x >> (w - s))) & mask;
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    shift_unit_pipe_if #(.WIDTH(32), .TAG_W(5)) mif ();
    shift_unit_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    always @(negedge clk) begin : mon_main
        exp_t e;
        if (!rst && mif.out_valid && mif.out_ready) begin
            if (mq.size() == 0) begin
                check("main_unexpected_output", 64'd1, 64'd0);
            end else begin
                e = mq.pop_front();
                check("main_data", 64'(mif.out_data), e.d);
                check("main_tag", 64'(mif.out_tag), 64'(e.tag));
                check("main_illegal", 64'(mif.out_illegal), 64'(e.ill));
                if (e.lat) check("main_latency", 64'(cyc - e.icyc), 64'd2);
            end
        end
    end

    task automatic issue(input int i, input bit push, input bit lat);
        int   w;
        exp_t e;
        @(posedge clk);
        #1;
        mif.in_valid = 1'b1;
        mif.in_op    = vt[i].op;
        mif.in_data  = vt[i].d;
        mif.in_shamt = vt[i].sh;
        mif.in_tag   = 5'(i);
        w = 0;
        @(negedge clk);
        while (!mif.in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (!mif.in_ready) begin
            check("main_in_ready_timeout", 64'(mif.in_ready), 64'd1);
        end else if (push && !mif.flush) begin
            e.d = {32'h0, vt[i].ed};
            e.tag = 5'(i);
            e.ill = vt[i].ill;
            e.icyc = cyc;
            e.lat = lat;
            mq.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        mif.in_valid = 1'b0;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        mif.out_ready = v;
    endtask

    task automatic drain_main();
        int w;
        w = 0;
        while (mq.size() > 0 && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("main_drain_empty", 64'(mq.size()), 64'd0);
    endtask

    initial begin : main_seq
        logic [31:0] sd;
        logic [4:0]  st;
        int          w;
        vt = '{
            '{3'd0, 32'h00000404, 5'd16, 32'h04040000, 1'b0},
            '{3'd1, 32'h02020000, 5'd8,  32'h00020200, 1'b0},
            '{3'd2, 32'h80800000, 5'd16, 32'hffff8080, 1'b0},
            '{3'd2, 32'h80800000, 5'd24, 32'hffffff80, 1'b0},
            '{3'd3, 32'h00000001, 5'd1,  32'h80000000, 1'b0},
            '{3'd4, 32'h80000001, 5'd4,  32'h00000018, 1'b0},
            '{3'd2, 32'h7fffffff, 5'd31, 32'h00000000, 1'b0},
            '{3'd0, 32'hdeadbeef, 5'd0,  32'hdeadbeef, 1'b0},
            '{3'd1, 32'hdeadbeef, 5'd0,  32'hdeadbeef, 1'b0},
            '{3'd2, 32'hdeadbeef, 5'd0,  32'hdeadbeef, 1'b0},
            '{3'd3, 32'hdeadbeef, 5'd0,  32'hdeadbeef, 1'b0},
            '{3'd4, 32'hdeadbeef, 5'd0,  32'hdeadbeef, 1'b0},
            '{3'd6, 32'h12345678, 5'd3,  32'h00000000, 1'b1},
            '{3'd3, 32'h12345678, 5'd8,  32'h78123456, 1'b0},
            '{3'd4, 32'h12345678, 5'd8,  32'h34567812, 1'b0},
            '{3'd1, 32'h80000000, 5'd31, 32'h00000001, 1'b0},
            '{3'd2, 32'h80000000, 5'd31, 32'hffffffff, 1'b0},
            '{3'd0, 32'hffffffff, 5'd4,  32'hfffffff0, 1'b0},
            '{3'd7, 32'hffffffff, 5'd0,  32'h00000000, 1'b1},
            '{3'd0, 32'h00000001, 5'd4,  32'h00000010, 1'b0},
            '{3'd1, 32'h00010000, 5'd8,  32'h00000100, 1'b0},
            '{3'd2, 32'hf0000000, 5'd4,  32'hff000000, 1'b0},
            '{3'd3, 32'h0000000f, 5'd4,  32'hf0000000, 1'b0},
            '{3'd4, 32'hf0000000, 5'd8,  32'h000000f0, 1'b0},
            '{3'd0, 32'h00000003, 5'd30, 32'hc0000000, 1'b0},
            '{3'd0, 32'h00000001, 5'd31, 32'h80000000, 1'b0}
        };
        mif.in_valid  = 1'b0;
        mif.in_op     = '0;
        mif.in_data   = '0;
        mif.in_shamt  = '0;
        mif.in_tag    = '0;
        mif.flush     = 1'b0;
        mif.out_ready = 1'b1;
        #2;
        rst    = 1'b1;
        rst_sw = 1'b1;
        #1;
        check("reset_out_valid", 64'(mif.out_valid), 64'd0);
        check("reset_out_data", 64'(mif.out_data), 64'd0);
        check("reset_out_tag", 64'(mif.out_tag), 64'd0);
        check("reset_out_illegal", 64'(mif.out_illegal), 64'd0);
        check("reset_in_ready", 64'(mif.in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        rst_sw = 1'b0;
        sw_go  = 1'b1;

        // Directed ops, back to back, consumer always ready.
        for (int i = 0; i < 19; i++) issue(i, 1'b1, 1'b1);
        idle();
        drain_main();

        // Backpressure: consumer stalls for 5 cycles after the first result.
        set_ready(1'b0);
        fork
            begin
                for (int i = 19; i < 25; i++) issue(i, 1'b1, 1'b0);
                idle();
            end
            begin
                w = 0;
                @(negedge clk);
                while (!mif.out_valid && w < 20) begin
                    w++;
                    @(negedge clk);
                end
                check("bp_first_valid", 64'(mif.out_valid), 64'd1);
                sd = mif.out_data;
                st = mif.out_tag;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_stable_data", 64'(mif.out_data), 64'(sd));
                    check("bp_stable_tag", 64'(mif.out_tag), 64'(st));
                    check("bp_stable_valid", 64'(mif.out_valid), 64'd1);
                end
                check("bp_in_ready_full", 64'(mif.in_ready), 64'd0);
                set_ready(1'b1);
            end
        join
        drain_main();

        // Flush drops two in-flight ops and a third presented with it.
        set_ready(1'b0);
        issue(0, 1'b0, 1'b0);
        issue(1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        mif.in_valid = 1'b1;
        mif.in_op    = vt[2].op;
        mif.in_data  = vt[2].d;
        mif.in_shamt = vt[2].sh;
        mif.in_tag   = 5'd2;
        mif.flush    = 1'b1;
        @(posedge clk);
        #1;
        mif.flush    = 1'b0;
        mif.in_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("flush_out_valid", 64'(mif.out_valid), 64'd0);
        end
        set_ready(1'b1);
        issue(5, 1'b1, 1'b1);
        idle();
        drain_main();

        // Asynchronous reset with two ops in flight.
        set_ready(1'b0);
        issue(3, 1'b0, 1'b0);
        issue(4, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        check("rst_pre_out_valid", 64'(mif.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_out_valid", 64'(mif.out_valid), 64'd0);
        check("rst_async_out_data", 64'(mif.out_data), 64'd0);
        check("rst_async_in_ready", 64'(mif.in_ready), 64'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        mif.out_ready = 1'b1;
        issue(25, 1'b1, 1'b1);
        idle();
        drain_main();

        w = 0;
        while (sw_done != 3'b111 && w < 50000) begin
            @(posedge clk);
            w++;
        end
        check("sweep_completed", 64'(sw_done), 64'd7);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
        localparam int W  = (gi == 0) ? 8 : (gi == 1) ? 32 : 64;
        localparam int S  = (gi == 0) ? 1 : (gi == 1) ? 5 : 3;
        localparam int LW = $clog2(W);

        shift_unit_pipe_if #(.WIDTH(W), .TAG_W(5)) sif ();
        shift_unit_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(5)) u_dut (
            .clk (clk),
            .rst (rst_sw),
            .bus (sif)
        );

        exp_t q [$];

        always @(negedge clk) begin : mon_sw
            exp_t e;
            if (!rst_sw && sif.out_valid && sif.out_ready) begin
                if (q.size() == 0) begin
                    check($sformatf("sw%0d_unexpected_output", gi), 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check($sformatf("sw%0d_data", gi), 64'(sif.out_data), e.d);
                    check($sformatf("sw%0d_tag", gi), 64'(sif.out_tag), 64'(e.tag));
                    check($sformatf("sw%0d_illegal", gi), 64'(sif.out_illegal), 64'(e.ill));
                end
            end
        end

        initial begin : drv_sw
            int          fired;
            int          budget;
            int          w;
            bit          pend;
            logic [63:0] rd;
            exp_t        e;
            sif.in_valid  = 1'b0;
            sif.in_op     = '0;
            sif.in_data   = '0;
            sif.in_shamt  = '0;
            sif.in_tag    = '0;
            sif.flush     = 1'b0;
            sif.out_ready = 1'b0;
            fired  = 0;
            budget = 0;
            pend   = 1'b0;
            wait (sw_go);
            while (fired < 1000 && budget < 20000) begin
                @(posedge clk);
                #1;
                sif.out_ready = ($urandom_range(3) != 0);
                if (!pend) begin
                    sif.in_valid = 1'b0;
                    if ($urandom_range(4) != 0) begin
                        pend = 1'b1;
                        sif.in_valid = 1'b1;
                        sif.in_op = ($urandom_range(15) == 0) ? 3'($urandom_range(7, 5))
                                                              : 3'($urandom_range(4));
                        rd = {$urandom, $urandom};
                        sif.in_data  = rd[W-1:0];
                        sif.in_shamt = LW'($urandom);
                        sif.in_tag   = 5'($urandom);
                    end
                end
                @(negedge clk);
                if (pend && sif.in_ready) begin
                    e.d    = ref_shift(W, sif.in_op, 64'(sif.in_data), int'(sif.in_shamt));
                    e.tag  = sif.in_tag;
                    e.ill  = (sif.in_op > 3'd4);
                    e.icyc = cyc;
                    e.lat  = 1'b0;
                    q.push_back(e);
                    fired++;
                    pend = 1'b0;
                end
                budget++;
            end
            check($sformatf("sw%0d_ops_accepted", gi), 64'(fired), 64'd1000);
            @(posedge clk);
            #1;
            sif.in_valid  = 1'b0;
            sif.out_ready = 1'b1;
            w = 0;
            while (q.size() > 0 && w < 200) begin
                @(negedge clk);
                #1;
                w++;
            end
            check($sformatf("sw%0d_drain_empty", gi), 64'(q.size()), 64'd0);
            sw_done[gi] = 1'b1;
        end
    end
endmodule
`default_nettype wire
